line_fill_ctrl: RTL
===================

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, giving beats per line fill.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, giving max clk cycles allowed between beats.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, cache-side request present.
REQ-006 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port req_rd, input, 1, 1 = line read (burst), 0 = single-word write.
REQ-008 SHALL have port req_addr, input, 32, request address.
REQ-009 SHALL have port req_wdata, input, 64, write word.
REQ-010 SHALL have port fill_valid, output, 1, one-cycle pulse: line or write complete.
REQ-011 SHALL have port fill_data, output, 64*BURST_LEN, assembled line, beat k in bits [64k+63:64k].
REQ-012 SHALL have port fill_err, output, 1, one-cycle pulse: transaction aborted by timeout.
REQ-013 SHALL have port mem_we, output, 1, memory command; 1 = READ, 0 = write.
REQ-014 SHALL have port mem_addr, output, 32, memory address.
REQ-015 SHALL have port mem_data, inout, 64, memory data bus; driven only during a write, else high-Z.
REQ-016 SHALL have port mem_stb, input, 1, asynchronous beat strobe; each transition is one beat.

Function
REQ-017 SHALL implement states IDLE, ISSUE, FILL, WRITE, DONE, ERR.
REQ-018 IDLE: req_ready=1; req_valid=1 registers req_rd/req_addr/req_wdata, drives mem_we=req_rd and mem_addr=req_addr, and enters ISSUE.
REQ-019 ISSUE SHALL last exactly one cycle, ignore all strobe transitions, then go to FILL if req_rd else WRITE.
REQ-020 SHALL synchronize mem_stb through two flops and detect either edge; mem_data SHALL pass a matching two-stage register so the data captured belongs to the same beat.
REQ-021 FILL: each detected edge stores the delayed data at beat index k (k=0..BURST_LEN-1) and increments k; the edge with k=BURST_LEN-1 enters DONE.
REQ-022 WRITE: mem_data drives the registered wdata; the first detected edge enters DONE and releases mem_data in that same cycle.
REQ-023 DONE: fill_valid=1 for one cycle, fill_data held until the next DONE, return to IDLE; mem_we and mem_addr hold their last values.
REQ-024 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE SHALL be ignored, not queued.
REQ-025 Strobe edges in IDLE, ISSUE, DONE or ERR SHALL be discarded and SHALL NOT advance k.
REQ-026 Beat counter width SHALL be $clog2(BURST_LEN); k resets to 0 on entry to ISSUE.
REQ-027 Minimum request-to-fill_valid latency SHALL be 2 + synchronizer delay (2) + beat spacing cycles.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, k=0, req_ready=1, fill_valid=0, fill_err=0, fill_data=0, mem_we=0, mem_addr=0, mem_data high-Z, and clear the synchronizers.
REQ-029 Reset during FILL or WRITE SHALL discard the partial line without asserting fill_valid or fill_err.

Configuration
REQ-030 With LFC_TIMEOUT_EN defined, a counter cleared on every accepted beat and on entry to FILL/WRITE SHALL move FILL or WRITE to ERR after TIMEOUT_CYCLES cycles without a beat; ERR pulses fill_err one cycle, tristates mem_data, returns to IDLE.
REQ-031 Without LFC_TIMEOUT_EN, no counter or ERR path SHALL exist; fill_err SHALL be tied 0 and FILL/WRITE wait indefinitely.

Structure
REQ-032 Shared package lfc_pkg SHALL hold the state enum, the 64-bit beat width, the READ=1 encoding, and BURST_LEN/TIMEOUT_CYCLES defaults.
REQ-033 Sub-module stb_sync SHALL contain the two-flop synchronizer and the edge detector; everything else lives in line_fill_ctrl.

Verification
REQ-034 Read addr 32'h100, memory model 8 beats -> fill_valid once; beat k = 64'h100 + 64*k (beat 0 = 64'h100, beat 7 = 64'h2C0).
REQ-035 Write addr 32'h40, wdata 64'hDEADBEEF, one strobe edge -> mem_data = DEADBEEF until that edge, fill_valid, then high-Z.
REQ-036 Read with strobe stuck after 3 beats, LFC_TIMEOUT_EN defined -> fill_err pulse 64 cycles after beat 3, no fill_valid, back in IDLE.
REQ-037 rst_n low after beat 4 of a read -> outputs at reset values, no pulses; a following read to 32'h200 completes with beat 0 = 64'h200.
REQ-038 Back-to-back reads 32'h0 then 32'h1000, req_valid held high -> two fill_valid pulses, second line starts at 64'h1000, no beat carried over.
REQ-039 Stray strobe toggles in IDLE, then a read -> k starts at 0; line matches REQ-034 pattern.

Source files
------------

// File: rtl/lfc_pkg.sv
// Shared types and constants for the line-fill controller.
// LFC_TIMEOUT_EN (see line_fill_ctrl) only makes the ERR state reachable.
package lfc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FILL,
        WRITE,
        DONE,
        ERR
    } lfc_state_t;

    localparam int   BEAT_W             = 64;
    localparam logic MEM_READ           = 1'b1;
    localparam int   DEF_BURST_LEN      = 8;
    localparam int   DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/stb_sync.sv
// Two-flop synchronizer for the asynchronous beat strobe plus either-edge
// detector; the data bus rides a matching two-stage pipe so edge and data stay paired.
module stb_sync #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              stb_edge,
    output logic [DATA_W-1:0] data_sync
);

    logic              stb_p0, stb_p1, stb_p2;
    logic [DATA_W-1:0] data_p0, data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_p0  <= 1'b0;
            stb_p1  <= 1'b0;
            stb_p2  <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
        end else begin
            stb_p0  <= stb_async;
            stb_p1  <= stb_p0;
            stb_p2  <= stb_p1;
            data_p0 <= data_async;
            data_p1 <= data_p0;
        end
    end

    assign stb_edge  = stb_p1 ^ stb_p2;
    assign data_sync = data_p1;

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache line-fill / single-word write controller on a strobe-paced memory bus.
// Define LFC_TIMEOUT_EN to abort FILL/WRITE into ERR after TIMEOUT_CYCLES idle cycles.
module line_fill_ctrl
    import lfc_pkg::*;
#(
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rd,
    input  logic [31:0]                   req_addr,
    input  logic [BEAT_W-1:0]             req_wdata,
    output logic                          fill_valid,
    output logic [BEAT_W*BURST_LEN-1:0]   fill_data,
    output logic                          fill_err,
    output logic                          mem_we,
    output logic [31:0]                   mem_addr,
    inout  wire  [BEAT_W-1:0]             mem_data,
    input  logic                          mem_stb
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    lfc_state_t                   state, state_nxt;
    logic [CNT_W-1:0]             beat_k;
    logic                         beat_last;
    logic                         req_rd_q;
    logic [BEAT_W-1:0]            wdata_q;
    logic [BEAT_W*BURST_LEN-1:0]  line_buf, line_nxt;
    logic                         stb_edge;
    logic [BEAT_W-1:0]            beat_data;

    stb_sync #(.DATA_W(BEAT_W)) u_stb_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .stb_async (mem_stb),
        .data_async(mem_data),
        .stb_edge  (stb_edge),
        .data_sync (beat_data)
    );

    assign beat_last = (beat_k == CNT_W'(BURST_LEN - 1));

`ifdef LFC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            busy;
    logic            to_hit;

    assign busy   = (state == FILL) || (state == WRITE);
    assign to_hit = busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == ISSUE || (busy && stb_edge))
            to_cnt <= '0;
        else if (busy)
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign fill_err = (state == ERR);
`else
    assign fill_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid) state_nxt = ISSUE;
            ISSUE: state_nxt = (req_rd_q == MEM_READ) ? FILL : WRITE;
            FILL: begin
                if (stb_edge && beat_last) state_nxt = DONE;
`ifdef LFC_TIMEOUT_EN
                else if (!stb_edge && to_hit) state_nxt = ERR;
`endif
            end
            WRITE: begin
                if (stb_edge) state_nxt = DONE;
`ifdef LFC_TIMEOUT_EN
                else if (to_hit) state_nxt = ERR;
`endif
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        line_nxt = line_buf;
        line_nxt[int'(beat_k)*BEAT_W +: BEAT_W] = beat_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rd_q  <= 1'b0;
            beat_k    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            fill_data <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                req_rd_q <= req_rd;
                mem_we   <= req_rd;
                mem_addr <= req_addr;
                beat_k   <= '0;
            end
            if (state == FILL && stb_edge) begin
                beat_k <= beat_k + CNT_W'(1);
                if (beat_last)
                    fill_data <= line_nxt;
            end
        end
    end

    // Pure datapath: a partial line is never published, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid)
            wdata_q <= req_wdata;
        if (state == FILL && stb_edge)
            line_buf <= line_nxt;
    end

    assign req_ready  = (state == IDLE);
    assign fill_valid = (state == DONE);

    // Bus is released combinationally on the completing edge.
    assign mem_data = (state == WRITE && !stb_edge) ? wdata_q : {BEAT_W{1'bz}};

endmodule
